// File: rtl/vga_sync_gen.sv
// vga_sync_gen
// ------------
// 640x480 @ 60 Hz VGA timing generator running from the 100 MHz board clock.
// A clock divider produces a one-clk pixel strobe (p_tick). On each p_tick
// the horizontal and vertical counters advance. The sync and video_on
// outputs are registered from the next-state counter values, so they always
// line up with the pixel_x/pixel_y being presented.
//
// Ports
//   clk         system clock (100 MHz)
//   rst_n       asynchronous active-low reset
//   hsync       horizontal sync, active low, registered
//   vsync       vertical sync, active low, registered
//   video_on    high while (pixel_x, pixel_y) is inside the visible area
//   p_tick      one-clk strobe, once per pixel period
//   pixel_x     current horizontal count, 0..H_TOTAL-1
//   pixel_y     current vertical count, 0..V_TOTAL-1
//   frame_tick  one-clk strobe on the last pixel of each frame

module vga_sync_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       p_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       frame_tick
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    // Both counters are 10 bits wide; anything larger cannot be represented.
    if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 2) begin : g_param_check
        $error("vga_sync_gen: illegal parameter set (totals must fit 10 bits, CLK_DIV >= 2)");
    end

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [9:0]       h_cnt, v_cnt;
    logic [9:0]       h_nxt, v_nxt;

    // ------------------------------------------------------------------
    // Pixel-tick divider
    // ------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign p_tick = (div_cnt == DIV_LAST);

    // ------------------------------------------------------------------
    // Next-state counters
    // ------------------------------------------------------------------
    // NOTE: every signal assigned in this block gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        h_nxt = h_cnt;
        v_nxt = v_cnt;
        if (p_tick) begin
            // >= rather than == keeps the counters bounded even if a
            // register were ever disturbed past the last count.
            if (h_cnt >= H_LAST) begin
                h_nxt = '0;
                if (v_cnt >= V_LAST) begin
                    v_nxt = '0;
                end else begin
                    v_nxt = v_cnt + 10'd1;
                end
            end else begin
                h_nxt = h_cnt + 10'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Counter and output registers
    // ------------------------------------------------------------------
    // Sync/video flags are decoded from h_nxt/v_nxt and loaded on the same
    // edge as the counters, so they describe the pixel now on pixel_x/y.
    // Loading only on p_tick keeps video_on low after reset until the
    // first pixel step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt    <= '0;
            v_cnt    <= '0;
            hsync    <= 1'b1;
            vsync    <= 1'b1;
            video_on <= 1'b0;
        end else if (p_tick) begin
            h_cnt    <= h_nxt;
            v_cnt    <= v_nxt;
            hsync    <= !((h_nxt >= HS_START) && (h_nxt <= HS_END));
            vsync    <= !((v_nxt >= VS_START) && (v_nxt <= VS_END));
            video_on <= (h_nxt < H_VIS) && (v_nxt < V_VIS);
        end
    end

    assign pixel_x    = h_cnt;
    assign pixel_y    = v_cnt;
    assign frame_tick = p_tick && (h_cnt == H_LAST) && (v_cnt == V_LAST);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen. Two instances share clock and reset: one with the
// default 640x480 timing, one with a shrunken timing (16x11 total, CLK_DIV=2)
// so that whole frames fit in a short run. A reference model derives every
// output from the number of clock edges since reset release; its predictions
// are queued at each rising edge and compared at the following falling edge.

module tb_vga_sync_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       d_hs, d_vs, d_von, d_pt, d_ft;
    logic [9:0] d_x, d_y;
    logic       s_hs, s_vs, s_von, s_pt, s_ft;
    logic [9:0] s_x, s_y;

    int total = 0;
    int bad   = 0;
    int e     = 0;
    bit sb_en = 1'b1;

    logic [24:0] q_d[$];
    logic [24:0] q_s[$];

    localparam logic [31:0] RST_VAL = 32'h0180_0000;

    wire [24:0] got_d = {d_hs, d_vs, d_von, d_pt, d_ft, d_x, d_y};
    wire [24:0] got_s = {s_hs, s_vs, s_von, s_pt, s_ft, s_x, s_y};

    vga_sync_gen dut (
        .clk(clk), .rst_n(rst_n), .hsync(d_hs), .vsync(d_vs), .video_on(d_von),
        .p_tick(d_pt), .pixel_x(d_x), .pixel_y(d_y), .frame_tick(d_ft)
    );

    vga_sync_gen #(
        .CLK_DIV(2), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .hsync(s_hs), .vsync(s_vs), .video_on(s_von),
        .p_tick(s_pt), .pixel_x(s_x), .pixel_y(s_y), .frame_tick(s_ft)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected outputs after e clock edges since reset release.
    function automatic logic [24:0] model(input int d, input int hd, input int hf,
                                          input int hs, input int hb, input int vd,
                                          input int vf, input int vs, input int vb,
                                          input int edges);
        int ht, vt, n, x, y;
        logic pt, hsn, vsn, von, ft;
        ht  = hd + hf + hs + hb;
        vt  = vd + vf + vs + vb;
        n   = edges / d;
        x   = n % ht;
        y   = (n / ht) % vt;
        pt  = ((edges % d) == d - 1);
        von = (n != 0) && (x < hd) && (y < vd);
        hsn = !((x >= hd + hf) && (x < hd + hf + hs));
        vsn = !((y >= vd + vf) && (y < vd + vf + vs));
        ft  = pt && (x == ht - 1) && (y == vt - 1);
        return {hsn, vsn, von, pt, ft, 10'(x), 10'(y)};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) e <= 0;
        else        e <= e + 1;
    end

    // Scoreboard: predict at the edge, compare half a cycle later.
    always @(posedge clk) begin
        #1;
        if (sb_en) begin
            q_d.push_back(model(4, 640, 16, 96, 48, 480, 10, 2, 33, e));
            q_s.push_back(model(2, 8, 2, 3, 3, 6, 1, 2, 2, e));
        end
    end

    always @(negedge clk) begin
        if (sb_en) begin
            if (q_d.size() > 0) check("sb_def", 32'(got_d), 32'(q_d.pop_front()));
            if (q_s.size() > 0) check("sb_small", 32'(got_s), 32'(q_s.pop_front()));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int cnt, clks, hs_lo_clk, hs_lo_pt, hs_first, hs_rise, xmax;
        int pt, von_pt, vs_pt, ftc, vs_fx, vs_fy, dft;
        logic prev_hs, von639, von640, v_7_5, v_8_0, v_0_6;

        // ---------------- reset held for 5 clocks ----------------
        rst_n = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("reset_def", 32'(got_d), RST_VAL);
        end
        check("reset_small", 32'(got_s), RST_VAL);
        rst_n = 1'b1;

        // First p_tick after three edges; the fourth edge moves to x=1.
        cnt = 0;
        do begin @(posedge clk); cnt++; #1; end while (!d_pt && cnt < 20);
        check("first_ptick_edges", 32'(cnt), 32'd3);
        @(posedge clk); #1;
        check("x_after_first_ptick", 32'(d_x), 32'd1);
        check("von_after_first_ptick", 32'(d_von), 32'd1);

        // p_tick period
        cnt = 0;
        do begin @(posedge clk); cnt++; #1; end while (!d_pt && cnt < 20);
        cnt = 0;
        do begin @(posedge clk); cnt++; #1; end while (!d_pt && cnt < 20);
        check("ptick_period", 32'(cnt), 32'd4);

        // ---------------- one full line, default timing ----------------
        clks = 0; hs_lo_clk = 0; hs_lo_pt = 0; hs_first = -1; hs_rise = -1; xmax = 0;
        prev_hs = d_hs; von639 = 1'bx; von640 = 1'bx;
        while (!(d_y == 10'd1 && d_x == 10'd0) && clks < 5000) begin
            @(negedge clk);
            clks++;
            if (!d_hs) begin
                hs_lo_clk++;
                if (d_pt) hs_lo_pt++;
                if (hs_first < 0) hs_first = int'(d_x);
            end else if (!prev_hs && hs_rise < 0) begin
                hs_rise = int'(d_x);
            end
            prev_hs = d_hs;
            if (d_y == 10'd0 && int'(d_x) > xmax) xmax = int'(d_x);
            if (d_y == 10'd0 && d_x == 10'd639) von639 = d_von;
            if (d_y == 10'd0 && d_x == 10'd640) von640 = d_von;
        end
        check("line_wrap_y", 32'(d_y), 32'd1);
        check("line_xmax", 32'(xmax), 32'd799);
        check("hs_low_clks", 32'(hs_lo_clk), 32'd384);
        check("hs_low_pticks", 32'(hs_lo_pt), 32'd96);
        check("hs_start_x", 32'(hs_first), 32'd656);
        check("hs_rise_x", 32'(hs_rise), 32'd752);
        check("von_639_0", 32'(von639), 32'd1);
        check("von_640_0", 32'(von640), 32'd0);

        // ---------------- full frame, small timing ----------------
        clks = 0;
        do begin @(negedge clk); clks++; end while (!s_ft && clks < 1000);
        clks = 0; pt = 0; von_pt = 0; vs_pt = 0; ftc = 0; vs_fx = -1; vs_fy = -1;
        hs_rise = -1; prev_hs = 1'b1; v_7_5 = 1'bx; v_8_0 = 1'bx; v_0_6 = 1'bx;
        do begin
            @(negedge clk);
            clks++;
            if (s_pt) begin
                pt++;
                if (s_von) von_pt++;
                if (!s_vs) vs_pt++;
            end
            if (s_ft) ftc++;
            if (!s_vs && vs_fx < 0) begin vs_fx = int'(s_x); vs_fy = int'(s_y); end
            if (s_hs && !prev_hs && hs_rise < 0) hs_rise = int'(s_x);
            prev_hs = s_hs;
            if (s_x == 10'd7 && s_y == 10'd5) v_7_5 = s_von;
            if (s_x == 10'd8 && s_y == 10'd0) v_8_0 = s_von;
            if (s_x == 10'd0 && s_y == 10'd6) v_0_6 = s_von;
        end while (!s_ft && clks < 1000);
        check("frame_clks", 32'(clks), 32'd352);
        check("frame_pticks", 32'(pt), 32'd176);
        check("frame_ticks", 32'(ftc), 32'd1);
        check("frame_tick_x", 32'(s_x), 32'd15);
        check("frame_tick_y", 32'(s_y), 32'd10);
        check("von_pixels", 32'(von_pt), 32'd48);
        check("vs_low_pticks", 32'(vs_pt), 32'd32);
        check("vs_start_x", 32'(vs_fx), 32'd0);
        check("vs_start_y", 32'(vs_fy), 32'd7);
        check("small_hs_rise_x", 32'(hs_rise), 32'd13);
        check("von_last_visible", 32'(v_7_5), 32'd1);
        check("von_right_edge", 32'(v_8_0), 32'd0);
        check("von_below_edge", 32'(v_0_6), 32'd0);

        // ---------------- asynchronous reset mid-line ----------------
        clks = 0;
        do begin @(negedge clk); clks++; end
        while (!(s_x == 10'd10 && s_y == 10'd5) && clks < 1000);
        check("reach_10_5", 32'({s_x, s_y}), 32'({10'd10, 10'd5}));
        @(posedge clk); #3;
        sb_en = 1'b0;
        q_d.delete();
        q_s.delete();
        rst_n = 1'b0;
        #1;
        check("async_rst_def", 32'(got_d), RST_VAL);
        check("async_rst_small", 32'(got_s), RST_VAL);
        @(negedge clk); #2;
        rst_n = 1'b1;
        cnt = 0; dft = 0;
        do begin
            @(posedge clk); cnt++; #3;
            if (cnt == 1) sb_en = 1'b1;
            if (d_ft) dft++;
        end while (!s_ft && cnt < 1000);
        check("restart_ft_edges", 32'(cnt), 32'd351);
        check("restart_ft_pos", 32'({s_x, s_y}), 32'({10'd15, 10'd10}));
        check("restart_def_no_ft", 32'(dft), 32'd0);

        repeat (20) @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
